// File: rtl/hybrid_pwm_sd_pkg.sv
// rtl/hybrid_pwm_sd_pkg.sv - shared width and midscale helpers for the hybrid PWM/sigma-delta DAC
// Purpose: constant functions used by the top level and every channel slice.
//   sd_width      : width of the scaled/sigma accumulator path (DIN_W + PWM_W).
//   midscale_hold : reset value of a hold register (2^(DIN_W-1) unsigned, 0 for two's-complement).
// Ports: none (package).
package hybrid_pwm_sd_pkg;

  function automatic int sd_width(input int din_w, input int pwm_w);
    return din_w + pwm_w;
  endfunction

  function automatic logic [63:0] midscale_hold(input int din_w, input bit signed_in);
    return signed_in ? 64'd0 : (64'd1 << (din_w - 1));
  endfunction

endpackage

// File: rtl/hybrid_sd_channel.sv
// rtl/hybrid_sd_channel.sv - one DAC channel: sample-to-threshold noise shaping and PWM compare
// Purpose: at each period boundary folds the held sample into a PWM threshold with a
//   first-order error carry, then compares the shared counter against it every cycle.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_boundary   : high in the cycle where the shared counter is at N-1
//   i_mute       : substitute midscale for the sample at the boundary
//   i_cnt        : shared PWM counter (pre-edge value)
//   i_hold       : held sample for this channel
//   o_dout       : registered pulse output
module hybrid_sd_channel
  import hybrid_pwm_sd_pkg::*;
#(
  parameter int DIN_W     = 16,
  parameter int PWM_W     = 5,
  parameter int SIGNED_IN = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_boundary,
  input  logic             i_mute,
  input  logic [PWM_W-1:0] i_cnt,
  input  logic [DIN_W-1:0] i_hold,
  output logic             o_dout
);

  localparam int              SW    = sd_width(DIN_W, PWM_W);
  localparam int              N     = 1 << PWM_W;
  localparam logic [DIN_W-1:0] MID_U = DIN_W'(midscale_hold(DIN_W, 1'b0));
  // Offset of one full threshold step keeps thr >= 1; gain N-2 keeps thr <= N-1.
  localparam logic [SW-1:0]   BASE  = SW'(1) << DIN_W;
  localparam logic [SW-1:0]   GAIN  = SW'(N - 2);

  logic [DIN_W-1:0] w_u;
  logic [SW-1:0]    w_scaled;
  logic [SW-1:0]    w_sigma;
  logic [PWM_W-1:0] r_thr;
  logic [DIN_W-1:0] r_err;

  always_comb begin
    w_u = i_hold;
    // Two's-complement to offset binary is just an MSB flip.
    if (SIGNED_IN != 0) w_u[DIN_W-1] = ~i_hold[DIN_W-1];
    if (i_mute) w_u = MID_U;
    w_scaled = BASE + SW'(w_u) * GAIN;
    w_sigma  = w_scaled + SW'(r_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_thr  <= PWM_W'(N / 2);
      r_err  <= '0;
      o_dout <= 1'b0;
    end else begin
      if (i_boundary) begin
        r_thr <= w_sigma[SW-1:DIN_W];
        r_err <= w_sigma[DIN_W-1:0];
      end
      // Uses the pre-edge threshold, so a new value shows up two cycles after the boundary.
      o_dout <= (i_cnt < r_thr);
    end
  end

endmodule

// File: rtl/hybrid_pwm_sd_mc.sv
// rtl/hybrid_pwm_sd_mc.sv - multi-channel hybrid PWM / sigma-delta DAC top level
// Purpose: shared period counter, frame handshake with one-deep hold, period tick,
//   and one hybrid_sd_channel per channel.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   din          : CHANNELS samples, channel c at [c*DIN_W +: DIN_W]
//   din_valid    : din holds a new frame
//   din_ready    : a frame is accepted this cycle (no frame pending)
//   mute         : force midscale at the next period boundary
//   period_tick  : one-cycle pulse in the cycle after each boundary
//   dout         : per-channel pulse outputs
module hybrid_pwm_sd_mc
  import hybrid_pwm_sd_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int DIN_W     = 16,
  parameter int PWM_W     = 5,
  parameter int SIGNED_IN = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*DIN_W-1:0] din,
  input  logic                      din_valid,
  output logic                      din_ready,
  input  logic                      mute,
  output logic                      period_tick,
  output logic [CHANNELS-1:0]       dout
);

  localparam logic [PWM_W-1:0] CNT_LAST = '1;
  localparam logic [DIN_W-1:0] MID_HOLD = DIN_W'(midscale_hold(DIN_W, SIGNED_IN != 0));

  logic [PWM_W-1:0]          r_cnt;
  logic [CHANNELS*DIN_W-1:0] r_hold;
  logic                      r_pending;
  logic                      r_tick;
  logic                      w_boundary;
  logic                      w_xfer;

  assign w_boundary  = (r_cnt == CNT_LAST);
  assign din_ready   = !r_pending;
  assign w_xfer      = din_valid && !r_pending;
  assign period_tick = r_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_hold    <= {CHANNELS{MID_HOLD}};
      r_pending <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + PWM_W'(1);
      r_tick <= w_boundary;
      // A transfer in the boundary cycle wins: channels see the old hold this
      // boundary and the new frame stays pending for the next one.
      if (w_xfer) begin
        r_hold    <= din;
        r_pending <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    hybrid_sd_channel #(
      .DIN_W     (DIN_W),
      .PWM_W     (PWM_W),
      .SIGNED_IN (SIGNED_IN)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .i_boundary (w_boundary),
      .i_mute     (mute),
      .i_cnt      (r_cnt),
      .i_hold     (r_hold[c*DIN_W +: DIN_W]),
      .o_dout     (dout[c])
    );
  end

endmodule

// File: tb/tb_hybrid_pwm_sd_mc.sv
// tb/tb_hybrid_pwm_sd_mc.sv - directed self-checking bench for hybrid_pwm_sd_mc
module tb_hybrid_pwm_sd_mc;

  localparam int CH = 2;
  localparam int DW = 16;
  localparam int PW = 5;
  localparam int N  = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [CH*DW-1:0] din = '0;
  logic [CH*DW-1:0] din_s = '0;
  logic             din_valid = 1'b0;
  logic             din_valid_s = 1'b0;
  logic             mute = 1'b0;
  logic             mute_s = 1'b0;
  logic             din_ready, din_ready_s;
  logic             period_tick, period_tick_s;
  logic [CH-1:0]    dout, dout_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hybrid_pwm_sd_mc #(.CHANNELS(CH), .DIN_W(DW), .PWM_W(PW), .SIGNED_IN(0)) u_dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .mute(mute), .period_tick(period_tick), .dout(dout));

  hybrid_pwm_sd_mc #(.CHANNELS(CH), .DIN_W(DW), .PWM_W(PW), .SIGNED_IN(1)) u_dut_s (
    .clk(clk), .reset(reset), .din(din_s), .din_valid(din_valid_s), .din_ready(din_ready_s),
    .mute(mute_s), .period_tick(period_tick_s), .dout(dout_s));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in a period_tick cycle (cnt=0); counts dout highs over one full period and
  // ends in the next period_tick cycle. pulse_at = cnt value at which a frame is offered.
  task automatic measure_period(input int pulse_at, output int h0, output int h1,
                                output int s0, output int s1);
    h0 = 0; h1 = 0; s0 = 0; s1 = 0;
    for (int i = 0; i < N; i++) begin
      if (i == pulse_at) begin
        din_valid   = 1'b1;
        din_valid_s = 1'b1;
      end
      step();
      din_valid   = 1'b0;
      din_valid_s = 1'b0;
      h0 += int'(dout[0]);
      h1 += int'(dout[1]);
      s0 += int'(dout_s[0]);
      s1 += int'(dout_s[1]);
    end
    n_cmp++;
    if (period_tick !== 1'b1) begin
      n_bad++;
      $display("FAIL period_align: period_tick=%0b required 1", period_tick);
    end
  endtask

  task automatic test_reset();
    int k, h0, h1, s0, s1;
    reset = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (dout !== 2'b00 || dout_s !== 2'b00 || period_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: dout=%b dout_s=%b tick=%b required 00 00 0", dout, dout_s, period_tick);
    end
    reset = 1'b0;
    n_cmp++;
    if (din_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: din_ready=%b required 1", din_ready);
    end
    k = 0; h0 = 0; h1 = 0; s0 = 0; s1 = 0;
    while (k < 40) begin
      step();
      k++;
      h0 += int'(dout[0]); h1 += int'(dout[1]);
      s0 += int'(dout_s[0]); s1 += int'(dout_s[1]);
      if (period_tick === 1'b1) break;
    end
    n_cmp++;
    if (k !== 32) begin
      n_bad++;
      $display("FAIL reset_first_tick: cycles=%0d required 32", k);
    end
    n_cmp++;
    if (h0 !== 16 || h1 !== 16 || s0 !== 16 || s1 !== 16) begin
      n_bad++;
      $display("FAIL reset_first_period: highs=%0d %0d %0d %0d required 16 16 16 16", h0, h1, s0, s1);
    end
  endtask

  task automatic test_idle();
    int h0, h1, s0, s1;
    measure_period(-1, h0, h1, s0, s1);
    n_cmp++;
    if (h0 !== 16 || h1 !== 16 || s0 !== 16 || s1 !== 16) begin
      n_bad++;
      $display("FAIL idle_midscale: highs=%0d %0d %0d %0d required 16 16 16 16", h0, h1, s0, s1);
    end
  endtask

  task automatic test_back_to_back();
    int k, h0, h1, s0, s1;
    bit low_ok;
    din = {16'h0000, 16'h0000};
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    low_ok = (din_ready === 1'b0);
    k = 1;
    while (k < 40) begin
      step();
      k++;
      if (period_tick === 1'b1) break;
      if (din_ready !== 1'b0) low_ok = 1'b0;
    end
    n_cmp++;
    if (!low_ok || k !== 32) begin
      n_bad++;
      $display("FAIL b2b_ready_low: low_ok=%0b cycles=%0d required 1 32", low_ok, k);
    end
    n_cmp++;
    if (din_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready_after_boundary: din_ready=%b required 1", din_ready);
    end
    din = {16'h8000, 16'h8000};
    measure_period(0, h0, h1, s0, s1);
    n_cmp++;
    if (h0 !== 1 || h1 !== 1) begin
      n_bad++;
      $display("FAIL b2b_first_frame: highs=%0d %0d required 1 1", h0, h1);
    end
    n_cmp++;
    if (din_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_pending_cleared: din_ready=%b required 1", din_ready);
    end
    measure_period(-1, h0, h1, s0, s1);
    n_cmp++;
    if (h0 !== 16 || h1 !== 16) begin
      n_bad++;
      $display("FAIL b2b_second_frame: highs=%0d %0d required 16 16", h0, h1);
    end
  endtask

  task automatic test_boundary_xfer();
    int h0, h1, s0, s1;
    din = {16'h0000, 16'h0000};
    measure_period(31, h0, h1, s0, s1);
    n_cmp++;
    if (h0 !== 16 || h1 !== 16 || din_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bxfer_pending_kept: highs=%0d %0d ready=%b required 16 16 0", h0, h1, din_ready);
    end
    measure_period(-1, h0, h1, s0, s1);
    n_cmp++;
    if (h0 !== 16 || h1 !== 16 || din_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bxfer_old_hold: highs=%0d %0d ready=%b required 16 16 1", h0, h1, din_ready);
    end
    measure_period(-1, h0, h1, s0, s1);
    n_cmp++;
    if (h0 !== 1 || h1 !== 1) begin
      n_bad++;
      $display("FAIL bxfer_applied: highs=%0d %0d required 1 1", h0, h1);
    end
  endtask

  task automatic test_patterns();
    int h0, h1, s0, s1, tot0, tot1, first1, second1, out_of_range;
    din = {16'h8000, 16'h0000};
    measure_period(0, h0, h1, s0, s1);
    for (int p = 0; p < 3; p++) begin
      measure_period(-1, h0, h1, s0, s1);
      n_cmp++;
      if (h0 !== 1 || h1 !== 16) begin
        n_bad++;
        $display("FAIL pattern_zero_mid p%0d: highs=%0d %0d required 1 16", p, h0, h1);
      end
    end
    din = {16'hFFFF, 16'h8000};
    measure_period(0, h0, h1, s0, s1);
    tot0 = 0; tot1 = 0; first1 = 0; second1 = 0; out_of_range = 0;
    for (int p = 0; p < 2048; p++) begin
      measure_period(-1, h0, h1, s0, s1);
      tot0 += h0;
      tot1 += h1;
      if (p == 0) first1 = h1;
      if (p == 1) second1 = h1;
      if (h1 < 1 || h1 > N - 1) out_of_range++;
    end
    n_cmp++;
    if (first1 !== 30 || second1 !== 31) begin
      n_bad++;
      $display("FAIL pattern_full_start: thr=%0d %0d required 30 31", first1, second1);
    end
    n_cmp++;
    if (tot1 !== 63487 || out_of_range !== 0) begin
      n_bad++;
      $display("FAIL pattern_full_total: highs=%0d range_err=%0d required 63487 0", tot1, out_of_range);
    end
    n_cmp++;
    if (tot0 !== 32768) begin
      n_bad++;
      $display("FAIL pattern_mid_total: highs=%0d required 32768", tot0);
    end
  endtask

  task automatic test_mute();
    int h0, h1, s0, s1;
    mute = 1'b1;
    din = {16'hFFFF, 16'hFFFF};
    measure_period(0, h0, h1, s0, s1);
    n_cmp++;
    if (h0 !== 16) begin
      n_bad++;
      $display("FAIL mute_prior: high=%0d required 16", h0);
    end
    for (int p = 0; p < 2; p++) begin
      measure_period(-1, h0, h1, s0, s1);
      n_cmp++;
      if (h0 !== 16 || h1 !== 16) begin
        n_bad++;
        $display("FAIL mute_midscale p%0d: highs=%0d %0d required 16 16", p, h0, h1);
      end
    end
    mute = 1'b0;
    measure_period(-1, h0, h1, s0, s1);
    n_cmp++;
    if (h0 !== 16) begin
      n_bad++;
      $display("FAIL mute_release_lag: high=%0d required 16", h0);
    end
    measure_period(-1, h0, h1, s0, s1);
    n_cmp++;
    if (h0 !== 30) begin
      n_bad++;
      $display("FAIL mute_release_first: high=%0d required 30", h0);
    end
    measure_period(-1, h0, h1, s0, s1);
    n_cmp++;
    if (h0 !== 31) begin
      n_bad++;
      $display("FAIL mute_release_second: high=%0d required 31", h0);
    end
  endtask

  task automatic test_signed();
    int h0, h1, s0, s1;
    din_s = {16'h8000, 16'h0000};
    measure_period(0, h0, h1, s0, s1);
    measure_period(-1, h0, h1, s0, s1);
    n_cmp++;
    if (s0 !== 16 || s1 !== 1) begin
      n_bad++;
      $display("FAIL signed_zero_min: highs=%0d %0d required 16 1", s0, s1);
    end
    din_s = {16'h7FFF, 16'h0000};
    measure_period(0, h0, h1, s0, s1);
    measure_period(-1, h0, h1, s0, s1);
    n_cmp++;
    if (s0 !== 16 || s1 !== 30) begin
      n_bad++;
      $display("FAIL signed_max: highs=%0d %0d required 16 30", s0, s1);
    end
  endtask

  task automatic test_reset_mid();
    int k, h0, h1, s0, s1;
    din = {16'h0000, 16'h0000};
    for (int i = 0; i < 9; i++) begin
      if (i == 2) din_valid = 1'b1;
      step();
      din_valid = 1'b0;
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if (dout !== 2'b00 || dout_s !== 2'b00 || period_tick !== 1'b0 || din_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_state: dout=%b dout_s=%b tick=%b ready=%b required 00 00 0 1",
               dout, dout_s, period_tick, din_ready);
    end
    reset = 1'b0;
    k = 0; h0 = 0; h1 = 0; s0 = 0; s1 = 0;
    while (k < 40) begin
      step();
      k++;
      h0 += int'(dout[0]); h1 += int'(dout[1]);
      s0 += int'(dout_s[0]); s1 += int'(dout_s[1]);
      if (period_tick === 1'b1) break;
    end
    n_cmp++;
    if (k !== 32 || h0 !== 16 || h1 !== 16 || s0 !== 16 || s1 !== 16) begin
      n_bad++;
      $display("FAIL midreset_restart: cycles=%0d highs=%0d %0d %0d %0d required 32 16 16 16 16",
               k, h0, h1, s0, s1);
    end
    din = {16'hFFFF, 16'hFFFF};
    measure_period(0, h0, h1, s0, s1);
    n_cmp++;
    if (h0 !== 16 || h1 !== 16) begin
      n_bad++;
      $display("FAIL midreset_hold: highs=%0d %0d required 16 16", h0, h1);
    end
    measure_period(-1, h0, h1, s0, s1);
    n_cmp++;
    if (h0 !== 30 || h1 !== 30) begin
      n_bad++;
      $display("FAIL midreset_err: highs=%0d %0d required 30 30", h0, h1);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_back_to_back();
    test_boundary_xfer();
    test_patterns();
    test_mute();
    test_signed();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hybrid_pwm_sd_mc.md
HYBRID_PWM_SD_MC -- requirements
Module: hybrid_pwm_sd_mc

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent DAC channels.
REQ-002 SHALL have parameter DIN_W, default 16, sample width per channel.
REQ-003 SHALL have parameter PWM_W, default 5, PWM counter width; N = 2^PWM_W cycles per period.
REQ-004 SHALL have parameter SIGNED_IN, default 0; 1 means two's-complement input samples.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port din  input  CHANNELS*DIN_W  samples, channel c at bits [c*DIN_W +: DIN_W].
REQ-008 SHALL have port din_valid  input  1  din holds a new sample frame.
REQ-009 SHALL have port din_ready  output  1  block accepts a frame this cycle.
REQ-010 SHALL have port mute  input  1  forces midscale at the next period boundary.
REQ-011 SHALL have port period_tick  output  1  one-cycle pulse in the cycle after each period boundary.
REQ-012 SHALL have port dout  output  CHANNELS  per-channel pulse outputs.

Function
REQ-013 SHALL keep one shared PWM_W-bit counter cnt that increments every cycle and wraps N-1 -> 0.
REQ-014 The boundary SHALL be the cycle in which cnt == N-1.
REQ-015 Frame transfer SHALL occur when din_valid && din_ready; din_ready SHALL equal !pending.
REQ-016 A transfer SHALL load hold and set pending.
REQ-017 At the boundary, pending SHALL clear, unless a transfer occurs in the same cycle, in which case pending stays set.
REQ-018 At the boundary, each channel SHALL use the pre-edge hold value; a same-cycle transfer is used at the following boundary.
REQ-019 With no new frame, the boundary SHALL reuse the last hold value.
REQ-020 Per channel, u = sample with MSB inverted if SIGNED_IN, else sample unchanged.
REQ-021 If mute is high at the boundary, u SHALL be 2^(DIN_W-1).
REQ-022 Per channel, scaled = 2^DIN_W + u*(N-2), DIN_W+PWM_W bits unsigned, no overflow.
REQ-023 At the boundary: sigma = scaled + err; thr <= sigma[DIN_W+PWM_W-1:DIN_W]; err <= sigma[DIN_W-1:0].
REQ-024 thr SHALL stay within 1..N-1, so no period is fully low or fully high.
REQ-025 Every cycle, dout[c] <= (cnt < thr[c]) on the pre-edge values of cnt and thr[c]; dout lags cnt by one cycle.
REQ-026 A new threshold SHALL first affect dout in the second cycle after the boundary.
REQ-027 period_tick SHALL be registered high in the cycle after each boundary.

Reset
REQ-028 While reset is high, at each clock edge: cnt=0, thr=N/2, err=0, hold=midscale, pending=0, dout=0, period_tick=0.
REQ-029 Midscale hold SHALL be 2^(DIN_W-1) unsigned, or 0 when SIGNED_IN.
REQ-030 Reset asserted mid-period SHALL abandon the period; counting restarts at cnt=0 on the first cycle after reset deasserts.
REQ-031 din_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-032 Package hybrid_pwm_sd_pkg SHALL hold the scaled/sigma width function and the midscale constant function.
REQ-033 Sub-module hybrid_sd_channel (hold-to-thr arithmetic, err and thr registers, dout compare) SHALL be instantiated CHANNELS times.
REQ-034 cnt, the handshake and period_tick SHALL live in the top level only.

Verification
REQ-035 Scenarios use defaults, unsigned, unless stated.
REQ-036 After reset with no frames -> thr=16 on all channels; each dout high 16 of 32 cycles per period.
REQ-037 din=0x0000 -> thr=1 and err=0 every period; dout high exactly 1 cycle per period.
REQ-038 din=0x8000 -> thr=16, err=0 steady; with SIGNED_IN=1, din=0x0000 -> thr=16 as well.
REQ-039 din=0xFFFF -> thr=30 on the first period, then 31, with an occasional 30; dout high-cycle total over 2048 periods = 63487 +/-1.
REQ-040 Two frames back-to-back: first accepted, din_ready low until the boundary; the second transfers in the boundary cycle and is applied at the next boundary.
REQ-041 mute=1 with din=0xFFFF -> thr=16 from the next boundary; reset pulsed at cnt=9 -> all registers at reset values, dout=0, cnt restarts at 0.
